// File: rtl/tqv_crc32_spi_harness_if.sv
// Pin bundle of the TinyQV CRC-32 harness.
// The host side drives the inputs. The harness drives the outputs.
interface tqv_crc32_spi_harness_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tqv_crc32_spi_harness.sv
// Standalone harness for the TinyQV CRC-32 peripheral.
// The peripheral's register file is reached through an SPI mode-0 slave on the uio pins.
module tqv_crc32_spi_harness (
    input  logic                          clk,
    input  logic                          rst_n,
    tqv_crc32_spi_harness_if.slave        pins
);
    localparam logic [31:0] POLY = 32'hEDB88320;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } spi_state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] s, input logic [7:0] b);
        logic [31:0] c;
        c = s ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Bytes are consumed LSB byte first, up to four per commit.
    function automatic logic [31:0] crc_word(input logic [31:0] s, input logic [31:0] d,
                                             input logic [2:0] nbytes);
        logic [31:0] c;
        c = s;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nbytes) begin
                c = crc_byte(c, d[8*i +: 8]);
            end
        end
        return c;
    endfunction

    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    logic        cs_n_p0, cs_n_p1;
    logic        sck_p0, sck_p1, sck_p2;
    logic        mosi_p0, mosi_p1;
    logic        sck_rise, sck_fall;

    spi_state_t  fsm;
    logic [5:0]  bit_cnt;
    logic [31:0] shift_in;
    logic [31:0] shift_nxt;
    logic        wr_cmd;
    logic [1:0]  width_code;
    logic [5:0]  addr;
    logic [31:0] rd_shift;
    logic [31:0] rd_value;
    logic        miso;

    logic [2:0]  nbytes;
    logic [5:0]  nbits;
    logic        commit_fire;

    logic [31:0] crc_state;
    logic [31:0] byte_count;

    // Input synchronisers; sck_p2 is the previous sample used for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_n_p0 <= 1'b1;
            cs_n_p1 <= 1'b1;
            sck_p0  <= 1'b0;
            sck_p1  <= 1'b0;
            sck_p2  <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            cs_n_p0 <= pins.uio_in[0];
            cs_n_p1 <= cs_n_p0;
            sck_p0  <= pins.uio_in[3];
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            mosi_p0 <= pins.uio_in[1];
            mosi_p1 <= mosi_p0;
        end
    end

    assign sck_rise  = sck_p1 & ~sck_p2;
    assign sck_fall  = ~sck_p1 & sck_p2;
    assign shift_nxt = {shift_in[30:0], mosi_p1};
    assign nbytes    = width_bytes(width_code);
    assign nbits     = {nbytes, 3'b000};

    assign commit_fire = (fsm == ST_WDATA) && sck_rise && !cs_n_p1 &&
                         (bit_cnt == nbits - 6'd1);

    // The register value is taken from the address bits that are still being shifted in.
    always_comb begin
        rd_value = 32'h0;
        case (shift_nxt[5:0])
            6'h04:   rd_value = ~crc_state;
            6'h0C:   rd_value = crc_state;
            6'h10:   rd_value = byte_count;
            default: rd_value = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm        <= ST_CMD;
            bit_cnt    <= 6'd0;
            wr_cmd     <= 1'b0;
            width_code <= 2'b00;
            addr       <= 6'd0;
            miso       <= 1'b0;
        end else if (cs_n_p1) begin
            fsm     <= ST_CMD;
            bit_cnt <= 6'd0;
            miso    <= 1'b0;
        end else begin
            if (sck_rise) begin
                shift_in <= shift_nxt;
            end
            case (fsm)
                ST_CMD: begin
                    if (sck_rise) begin
                        if (bit_cnt == 6'd7) begin
                            wr_cmd     <= shift_nxt[7];
                            width_code <= shift_nxt[6:5];
                            bit_cnt    <= 6'd0;
                            fsm        <= ST_ADDR;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        if (bit_cnt == 6'd7) begin
                            addr    <= shift_nxt[5:0];
                            bit_cnt <= 6'd0;
                            if (wr_cmd) begin
                                fsm <= ST_WDATA;
                            end else begin
                                // Left-align the selected width so bit 31 is always the next MISO bit.
                                case (width_code)
                                    2'b00:   rd_shift <= {rd_value[7:0], 24'h000000};
                                    2'b01:   rd_shift <= {rd_value[15:0], 16'h0000};
                                    default: rd_shift <= rd_value;
                                endcase
                                fsm <= ST_RDATA;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (sck_rise) begin
                        if (bit_cnt == nbits - 6'd1) begin
                            fsm <= ST_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (sck_fall) begin
                        miso     <= rd_shift[31];
                        rd_shift <= {rd_shift[30:0], 1'b0};
                    end
                end
                ST_DONE: begin
                end
                default: fsm <= ST_CMD;
            endcase
        end
    end

    // CRC engine: a whole write is folded into the state in its commit cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_state  <= 32'hFFFFFFFF;
            byte_count <= 32'h0;
        end else if (commit_fire) begin
            if (addr == 6'h00) begin
                crc_state  <= crc_word(crc_state, shift_nxt, nbytes);
                byte_count <= byte_count + {29'd0, nbytes};
            end else if (addr == 6'h08 && shift_nxt[0]) begin
                crc_state  <= 32'hFFFFFFFF;
                byte_count <= 32'h0;
            end
        end
    end

    assign pins.uo_out  = ~crc_state[7:0];
    assign pins.uio_out = {5'b00000, miso, 2'b00};
    assign pins.uio_oe  = 8'h04;

    logic unused_ok;
    assign unused_ok = &{1'b0, pins.ena, pins.ui_in, pins.uio_in[7:4], pins.uio_in[2],
                         shift_in[31]};
endmodule

// File: tb/tb_tqv_crc32_spi_harness.sv
// Bench for tqv_crc32_spi_harness: directed SPI frames with hand-computed results.
// A passive SPI sniffer compares read data against the expected-value queue.
module tb_tqv_crc32_spi_harness;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs_n_drv = 1'b1;
    logic sck_drv = 1'b0;
    logic mosi_drv = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_val[$];
    string       exp_tag[$];

    tqv_crc32_spi_harness_if pins ();

    assign pins.ena    = 1'b1;
    assign pins.ui_in  = 8'h00;
    assign pins.uio_in = {4'b0000, sck_drv, 1'b0, mosi_drv, cs_n_drv};

    tqv_crc32_spi_harness dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (pins.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic int frame_bits(input logic [7:0] cmd);
        case (cmd[6:5])
            2'b00:   return 8;
            2'b01:   return 16;
            default: return 32;
        endcase
    endfunction

    // Sends cmd, addr, then the first 'nsend' of the 'ndata' data bits (MSB first).
    task automatic spi_xfer(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [31:0] data, input int ndata, input int nsend);
        logic [47:0] bits;
        logic [31:0] dshift;
        dshift = data << (32 - ndata);
        bits   = {cmd, addr, dshift};
        @(negedge clk);
        cs_n_drv = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 16 + nsend; k++) begin
            mosi_drv = bits[47 - k];
            repeat (6) @(negedge clk);
            sck_drv = 1'b1;
            repeat (6) @(negedge clk);
            sck_drv = 1'b0;
        end
        repeat (6) @(negedge clk);
        cs_n_drv = 1'b1;
        mosi_drv = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_write(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data);
        spi_xfer(cmd, addr, data, frame_bits(cmd), frame_bits(cmd));
    endtask

    task automatic spi_read(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [31:0] exp);
        exp_val.push_back(exp);
        exp_tag.push_back(tag);
        spi_xfer(cmd, addr, 32'h0, frame_bits(cmd), frame_bits(cmd));
    endtask

    // Passive sniffer: MISO is sampled on the host's SCK rising edge.
    logic [15:0] m_hdr;
    logic [31:0] m_obs;
    int          m_nb;
    initial begin : monitor
        forever begin
            @(negedge cs_n_drv);
            m_nb  = 0;
            m_hdr = 16'h0;
            m_obs = 32'h0;
            forever begin
                @(posedge sck_drv or posedge cs_n_drv);
                if (cs_n_drv) break;
                if (m_nb < 16) m_hdr = {m_hdr[14:0], mosi_drv};
                else if (m_nb < 16 + frame_bits(m_hdr[15:8])) m_obs = {m_obs[30:0], pins.uio_out[2]};
                m_nb++;
            end
            if (!m_hdr[15] && m_nb >= 16 + frame_bits(m_hdr[15:8])) begin
                if (exp_val.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: got %08h expected no read", m_obs);
                end else begin
                    check(exp_tag.pop_front(), m_obs, exp_val.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] msg [9];

    initial begin : stim
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("reset_uo_out", {24'h0, pins.uo_out}, 32'h00);
        check("reset_uio_oe", {24'h0, pins.uio_oe}, 32'h04);
        check("reset_uio_out", {24'h0, pins.uio_out}, 32'h00);
        spi_read("reset_result", 8'h40, 8'h04, 32'h00000000);
        spi_read("reset_state", 8'h40, 8'h0C, 32'hFFFFFFFF);
        spi_read("reset_count", 8'h40, 8'h10, 32'h00000000);

        foreach (msg[i]) spi_write(8'h80, 8'h00, {24'h0, msg[i]});
        check("bytes_uo_out", {24'h0, pins.uo_out}, 32'h26);
        spi_read("bytes_result", 8'h40, 8'h04, 32'hCBF43926);
        spi_read("bytes_count", 8'h40, 8'h10, 32'd9);
        spi_read("byte_read_result", 8'h00, 8'h04, 32'h00000026);

        spi_xfer(8'hA0, 8'h00, 32'h00004142, 16, 12);
        spi_read("abort_result", 8'h40, 8'h04, 32'hCBF43926);
        spi_read("abort_count", 8'h40, 8'h10, 32'd9);
        check("abort_uo_out", {24'h0, pins.uo_out}, 32'h26);

        spi_write(8'h80, 8'h08, 32'h1);
        spi_write(8'hC0, 8'h00, 32'h64636261);
        spi_read("word_result", 8'h40, 8'h04, 32'hED82CD11);
        spi_read("word_count", 8'h40, 8'h10, 32'd4);

        spi_write(8'h80, 8'h08, 32'h1);
        spi_write(8'hA0, 8'h00, 32'h00006261);
        spi_read("half_result", 8'h40, 8'h04, 32'h9E83486D);
        spi_read("half_count", 8'h40, 8'h10, 32'd2);
        spi_read("half_read_state", 8'h20, 8'h0C, 32'h0000B792);
        spi_read("unmapped_20", 8'h40, 8'h20, 32'h00000000);
        spi_read("data_reg_read", 8'h40, 8'h00, 32'h00000000);
        spi_read("ctrl_reg_read", 8'h40, 8'h08, 32'h00000000);
        check("cs_high_miso", {24'h0, pins.uio_out}, 32'h00);

        spi_write(8'h80, 8'h08, 32'h1);
        spi_read("reinit_result", 8'h40, 8'h04, 32'h00000000);
        spi_read("reinit_count", 8'h40, 8'h10, 32'h00000000);
        check("reinit_uo_out", {24'h0, pins.uo_out}, 32'h00);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_val.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
